// File: rtl/simp_frame_stats.sv
// -----------------------------------------------------------------------------
// simp_frame_stats
//
// This block sits downstream of the simp_fun datapath. It collects every
// FRAME_LEN accepted samples into one frame. For each frame it reports the
// sum, the minimum and the maximum on a held result port. That port has its
// own valid/ready handshake.
//
// Build option:
//   SIMP_FRAME_STATS_SAT_EN
//     When this macro is defined, the frame sum saturates at 2^SUM_W-1 and
//     out_ovf flags every frame whose sum saturated.
//     When it is not defined, the frame sum wraps modulo 2^SUM_W, no overflow
//     logic is built, and out_ovf is tied to 0.
//
// Parameters:
//   WIDTH     sample width (the same as simp_fun WIDTH)
//   FRAME_LEN samples per frame, must be >= 2
//   SUM_W     accumulator and out_sum width, must be >= WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   in_data is valid
//   in_ready   the block accepts in_data (decoded from state and out_ready)
//   in_data    unsigned sample
//   out_valid  a frame result is held on out_sum/out_min/out_max/out_ovf
//   out_ready  the consumer accepts the frame result
//   out_sum    unsigned frame sum
//   out_min    smallest sample in the frame
//   out_max    largest sample in the frame
//   out_ovf    the frame sum exceeded 2^SUM_W-1 (saturating build only)
// -----------------------------------------------------------------------------
module simp_frame_stats #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic             out_ovf
);

  localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] acc_sum;
  logic [WIDTH-1:0] acc_min;
  logic [WIDTH-1:0] acc_max;

  logic             accept;
  logic             last;
  logic [SUM_W-1:0] sum_upd;
  logic [WIDTH-1:0] min_upd;
  logic [WIDTH-1:0] max_upd;

`ifdef SIMP_FRAME_STATS_SAT_EN
  logic             acc_ovf;
  logic             ovf_upd;
  logic             out_ovf_q;
  logic [SUM_W:0]   sum_ext;

  // Clamp a one-bit-wider sum to the largest value that fits in SUM_W bits.
  function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W:0] s);
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction
`endif

  // The input side is ready in ACCUM. In HOLD it is ready only while the
  // held result is being delivered, so that no bubble appears between frames.
  assign in_ready  = (state == ACCUM) ? 1'b1 : out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST_IDX);

  // ---- combinational update of the running statistics ----
`ifdef SIMP_FRAME_STATS_SAT_EN
  assign sum_ext = {1'b0, acc_sum} + (SUM_W+1)'(in_data);
  assign sum_upd = sat_sum(sum_ext);
  assign ovf_upd = acc_ovf | sum_ext[SUM_W];
`else
  assign sum_upd = acc_sum + SUM_W'(in_data);
`endif
  assign min_upd = (in_data < acc_min) ? in_data : acc_min;
  assign max_upd = (in_data > acc_max) ? in_data : acc_max;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && last) state_nxt = HOLD;
      HOLD:  if (out_ready)      state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // ---- registered state, accumulators and held frame result ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ACCUM;
      cnt     <= '0;
      acc_sum <= '0;
      acc_min <= '1;
      acc_max <= '0;
      out_sum <= '0;
      out_min <= '0;
      out_max <= '0;
`ifdef SIMP_FRAME_STATS_SAT_EN
      acc_ovf   <= 1'b0;
      out_ovf_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (last) begin
          // The frame is complete: publish the result and restart empty.
          out_sum <= sum_upd;
          out_min <= min_upd;
          out_max <= max_upd;
          cnt     <= '0;
          acc_sum <= '0;
          acc_min <= '1;
          acc_max <= '0;
`ifdef SIMP_FRAME_STATS_SAT_EN
          out_ovf_q <= ovf_upd;
          acc_ovf   <= 1'b0;
`endif
        end else begin
          cnt     <= cnt + CNT_W'(1);
          acc_sum <= sum_upd;
          acc_min <= min_upd;
          acc_max <= max_upd;
`ifdef SIMP_FRAME_STATS_SAT_EN
          acc_ovf <= ovf_upd;
`endif
        end
      end
    end
  end

`ifdef SIMP_FRAME_STATS_SAT_EN
  assign out_ovf = out_ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_simp_frame_stats.sv
module tb_simp_frame_stats;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;
  localparam int SUM_W     = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SUM_W-1:0] out_sum;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic             out_ovf;

  simp_frame_stats #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_min(out_min), .out_max(out_max), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int s, input int mn, input int mx, input bit ovf);
    exp_t e;
    e.sum = SUM_W'(s);
    e.mn  = WIDTH'(mn);
    e.mx  = WIDTH'(mx);
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Monitor: each delivered frame result is compared with the next expected entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got sum %0d with no frame expected", out_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_sum", 32'(out_sum), 32'(e.sum));
        check("frame_min", 32'(out_min), 32'(e.mn));
        check("frame_max", 32'(out_max), 32'(e.mx));
        check("frame_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int d);
    in_valid = v;
    in_data  = WIDTH'(d);
    step();
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_min", 32'(out_min), 0);
    check("rst_out_max", 32'(out_max), 0);
    check("rst_out_ovf", 32'(out_ovf), 0);
    step(); step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();

    // 1: basic frame, back-to-back samples
    drive(1, 12); drive(1, 30); drive(1, 27);
    check("t1_no_early_valid", 32'(out_valid), 0);
    push_exp(219, 12, 150, 0);
    drive(1, 150);
    check("t1_latency_valid", 32'(out_valid), 1);
    drive(0, 0);
    check("t1_valid_one_cycle", 32'(out_valid), 0);

    // 2: backpressure, then delivery and accept in the same cycle
    out_ready = 1'b0;
    drive(1, 5); drive(1, 6); drive(1, 7);
    push_exp(26, 5, 8, 0);
    drive(1, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd200;
      #1;
      check("t2_stall_in_ready", 32'(in_ready), 0);
      check("t2_stall_valid", 32'(out_valid), 1);
      check("t2_stall_sum", 32'(out_sum), 26);
      step();
    end
    out_ready = 1'b1;
    in_data   = 8'd9;
    #1;
    check("t2_passthru_in_ready", 32'(in_ready), 1);
    step();
    drive(1, 10); drive(1, 11);
    push_exp(42, 9, 12, 0);
    drive(1, 12);
    drive(0, 0);

    // 3: input gaps
    drive(1, 1); drive(0, 99); drive(0, 99); drive(1, 2); drive(1, 3); drive(0, 99);
    check("t3_no_early_valid", 32'(out_valid), 0);
    push_exp(10, 1, 4, 0);
    drive(1, 4);
    check("t3_valid", 32'(out_valid), 1);
    drive(0, 0);

    // 4: overflow, then a small frame that must clear the sticky flag
    drive(1, 255); drive(1, 255); drive(1, 255);
`ifdef SIMP_FRAME_STATS_SAT_EN
    push_exp(511, 255, 255, 1);
`else
    push_exp(508, 255, 255, 0);
`endif
    drive(1, 255);
    drive(1, 1); drive(1, 1); drive(1, 1);
    push_exp(4, 1, 1, 0);
    drive(1, 1);
    drive(0, 0);

    // 5: reset in the middle of a frame
    drive(1, 50); drive(1, 60);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_rst_in_ready", 32'(in_ready), 1);
    check("t5_rst_out_sum", 32'(out_sum), 0);
    check("t5_rst_out_min", 32'(out_min), 0);
    check("t5_rst_out_max", 32'(out_max), 0);
    step(); step();
    rst = 1'b1;
    step();
    drive(1, 7); drive(1, 7); drive(1, 7);
    push_exp(28, 7, 7, 0);
    drive(1, 7);
    drive(0, 0);

    // 6: reset while a result is held
    out_ready = 1'b0;
    drive(1, 3); drive(1, 3); drive(1, 3); drive(1, 3);
    in_valid = 1'b0;
    check("t6_hold_valid", 32'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("t6_async_drop", 32'(out_valid), 0);
    step(); step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    drive(1, 100); drive(1, 50); drive(1, 75);
    push_exp(250, 25, 100, 0);
    drive(1, 25);
    drive(0, 0);
    step(); step();

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simp_frame_stats.md
Name: simp_frame_stats

Overview:
- Streaming consumer directly downstream of the registered simp_fun datapath; takes its WIDTH-bit c_out samples over a valid/ready handshake.
- Groups every FRAME_LEN accepted samples into a frame and reports the frame's sum, minimum and maximum on a held output port with its own valid/ready handshake.
- Lets the bench and later stages check simp_fun results per frame instead of per cycle.

Parameters:
- WIDTH, 8, sample width; matches simp_fun WIDTH.
- FRAME_LEN, 16, samples per frame; must be >= 2.
- SUM_W, 12, accumulator and out_sum width; must be >= WIDTH.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  unsigned sample (simp_fun c_out).
- out_valid  out  1  frame result held on out_sum, out_min, out_max and out_ovf.
- out_ready  in  1  consumer accepts the frame result.
- out_sum  out  SUM_W  unsigned sum of the frame's samples.
- out_min  out  WIDTH  smallest sample in the frame.
- out_max  out  WIDTH  largest sample in the frame.
- out_ovf  out  1  frame sum exceeded 2^SUM_W-1.

Behaviour:
- Accept: in_valid && in_ready at a rising edge. Deliver: out_valid && out_ready at a rising edge.
- Reset (rst=0, asynchronous):
  - State goes to ACCUM; sample count = 0.
  - acc_sum = 0, acc_min = all-ones, acc_max = 0, sticky overflow = 0.
  - All outputs = 0, except in_ready, which is 1 because in_ready is decoded from state ACCUM.
  - A frame in progress is discarded. A held result is lost and out_valid drops at once.
  - After release, the first accepted sample is sample 0 of a new frame.
- State ACCUM:
  - in_ready = 1, out_valid = 0.
  - On each accept: acc_sum += in_data, acc_min = min(acc_min, in_data), acc_max = max(acc_max, in_data), count++.
  - Arithmetic is unsigned. in_data is zero-extended to SUM_W+1 for the overflow check.
  - Accepting sample FRAME_LEN-1:
    - Loads out_sum, out_min and out_max with the updated values, including that sample.
    - Loads out_ovf with the updated sticky overflow.
    - Sets out_valid = 1 and moves to HOLD.
    - Clears accumulators and count to their reset values.
  - Latency: out_valid rises 1 cycle after the last sample's accept edge.
  - No accept (in_valid = 0): nothing changes. Gaps in the input are allowed.
- State HOLD:
  - out_valid = 1. Outputs stay stable until delivery.
  - in_ready = out_ready (combinational pass-through).
  - Delivery with in_valid = 1 in the same cycle: the sample is accepted as sample 0 of the next frame and the state goes to ACCUM. No bubble.
  - Delivery with in_valid = 0: the state goes to ACCUM and out_valid = 0 the next cycle.
  - out_ready = 0: the input stalls (in_ready = 0). in_valid and in_data are not sampled.
- Output registers keep their last values after delivery. Only out_valid qualifies them.
- No combinational path from in_valid or in_data to any output. in_ready depends only on state and out_ready.

Optional Feature:
- Macro: SIMP_FRAME_STATS_SAT_EN.
- Defined:
  - acc_sum saturates at 2^SUM_W-1 when a sum would exceed it.
  - The sticky overflow bit sets and out_ovf reports it for that frame.
  - The sticky bit clears at frame end.
- Not defined:
  - acc_sum wraps modulo 2^SUM_W.
  - No overflow tracking is built; out_ovf is tied to 0.
- min and max behave the same in both builds.

Test Plan:
1. Basic frame (FRAME_LEN=4, out_ready=1): samples 12, 30, 27, 150 back-to-back -> out_sum=219, out_min=12, out_max=150, out_ovf=0, out_valid for 1 cycle, 1 cycle after the 4th accept.
2. Backpressure: out_ready=0 for 5 cycles after the frame -> out_valid and outputs held, in_ready=0, in_valid ignored. Raising out_ready with in_valid=1 and sample 9 -> delivery and accept in the same cycle; 9 counted as sample 0 of the next frame.
3. Input gaps: in_valid toggling 1,0,0,1,1,0,1 with samples 1,2,3,4 -> result only after the 4th accept; out_sum=10, out_min=1, out_max=4.
4. Overflow (WIDTH=8, SUM_W=9, FRAME_LEN=4): four samples of 255 -> with SIMP_FRAME_STATS_SAT_EN: out_sum=511, out_ovf=1; without it: out_sum=1020 mod 512=508, out_ovf=0. Next frame 1,1,1,1 -> out_sum=4, out_ovf=0.
5. Reset mid-frame: 2 samples accepted, then rst=0 for 2 cycles -> outputs 0, in_ready=1 at once. After release, 4 samples of 7 -> out_sum=28 (earlier samples discarded).
6. Reset while in HOLD -> out_valid drops without waiting for a clock; no delivery occurs.
